// File: rtl/cpu_imem_arb_if.sv
// ---------------------------------------------------------------------------
// cpu_imem_arb_if
// Bundles the three buses around the instruction-memory arbiter:
//   fetch port : fetch_req, fetch_addr -> fetch_stall, fetch_valid, fetch_rdata
//   data port  : data_req, data_write, data_addr, data_wdata, data_wstrb
//                -> data_ack, data_rdata
//   RAM port   : mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb <- mem_rdata
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings (CPU fetch/load-store units and the RAM)
// ---------------------------------------------------------------------------
interface cpu_imem_arb_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic        fetch_valid;
    logic [31:0] fetch_rdata;

    logic        data_req;
    logic        data_write;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_ack;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        input  data_req, data_write, data_addr, data_wdata, data_wstrb,
        input  mem_rdata,
        output fetch_stall, fetch_valid, fetch_rdata,
        output data_ack, data_rdata,
        output mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output fetch_req, fetch_addr,
        output data_req, data_write, data_addr, data_wdata, data_wstrb,
        output mem_rdata,
        input  fetch_stall, fetch_valid, fetch_rdata,
        input  data_ack, data_rdata,
        input  mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/cpu_imem_arb.sv
// ---------------------------------------------------------------------------
// cpu_imem_arb
// Shares one single-ported instruction RAM between the CPU fetch port and the
// load/store (data) port. The grant is decided combinationally every cycle;
// a one-entry owner register remembers who was granted so the RAM response
// (one cycle later) is steered back as fetch_valid or data_ack.
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - cpu_imem_arb_if.slave (fetch, data and RAM buses)
//
// Parameter:
//   STARVE_LIMIT - consecutive stalled fetch cycles after which fetch beats
//                  data (1..15); only meaningful with IMEM_ARB_STARVE_EN.
//
// Build option:
//   IMEM_ARB_STARVE_EN - when defined, adds the fetch starvation counter.
//                        When undefined, data always has priority.
// ---------------------------------------------------------------------------
module cpu_imem_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clock,
    input  logic           reset,
    cpu_imem_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_e;

    owner_e state_r;
    owner_e state_nxt_s;

    logic data_elig_s;
    logic grant_fetch_s;
    logic grant_data_s;
    logic fetch_force_s;
    logic stall_s;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("cpu_imem_arb: STARVE_LIMIT must be in 1..15");
    end

`ifdef IMEM_ARB_STARVE_EN
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
    logic [3:0] starve_cnt_r;

    assign fetch_force_s = (starve_cnt_r == LIMIT_C);

    // Count consecutive stalled fetch cycles; any fetch grant or idle fetch clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_fetch_s || !bus.fetch_req) begin
            starve_cnt_r <= 4'd0;
        end else if (stall_s) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign fetch_force_s = 1'b0;
`endif

    // Grant decision. In the ack cycle data_req is still the old transaction,
    // so data is not eligible while the owner register says DATA.
    always_comb begin
        grant_fetch_s = 1'b0;
        grant_data_s  = 1'b0;
        data_elig_s   = bus.data_req & (state_r != DATA);
        if (reset) begin
            grant_fetch_s = 1'b0;
            grant_data_s  = 1'b0;
        end else if (bus.fetch_req && (!data_elig_s || fetch_force_s)) begin
            grant_fetch_s = 1'b1;
        end else if (data_elig_s) begin
            grant_data_s = 1'b1;
        end else begin
            grant_fetch_s = 1'b0;
            grant_data_s  = 1'b0;
        end
    end

    assign stall_s = bus.fetch_req & ~grant_fetch_s & ~reset;

    // Drive the RAM from whichever requester won; write fields only for data writes.
    always_comb begin
        bus.mem_req     = grant_fetch_s | grant_data_s;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = 32'h0000_0000;
        bus.mem_wdata   = 32'h0000_0000;
        bus.mem_wstrb   = 4'h0;
        bus.fetch_stall = stall_s;
        if (grant_data_s) begin
            bus.mem_addr = {bus.data_addr[31:2], 2'b00};
            if (bus.data_write) begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = bus.data_wdata;
                bus.mem_wstrb = bus.data_wstrb;
            end else begin
                bus.mem_write = 1'b0;
            end
        end else if (grant_fetch_s) begin
            bus.mem_addr = {bus.fetch_addr[31:2], 2'b00};
        end else begin
            bus.mem_addr = 32'h0000_0000;
        end
    end

    // Next owner is simply whoever was granted this cycle.
    always_comb begin
        state_nxt_s = IDLE;
        if (grant_fetch_s) begin
            state_nxt_s = FETCH;
        end else if (grant_data_s) begin
            state_nxt_s = DATA;
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // Owner register; reset drops any response still in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Steer the RAM response to the port that owned last cycle's access.
    always_comb begin
        bus.fetch_valid = 1'b0;
        bus.fetch_rdata = 32'h0000_0000;
        bus.data_ack    = 1'b0;
        bus.data_rdata  = 32'h0000_0000;
        case (state_r)
            FETCH: begin
                if (!reset) begin
                    bus.fetch_valid = 1'b1;
                    bus.fetch_rdata = bus.mem_rdata;
                end else begin
                    bus.fetch_valid = 1'b0;
                end
            end
            DATA: begin
                if (!reset) begin
                    bus.data_ack   = 1'b1;
                    bus.data_rdata = bus.mem_rdata;
                end else begin
                    bus.data_ack = 1'b0;
                end
            end
            default: begin
                bus.fetch_valid = 1'b0;
                bus.data_ack    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_imem_arb.sv
// ---------------------------------------------------------------------------
// tb_cpu_imem_arb
// Drives cpu_imem_arb with directed scenarios and a randomized phase. A RAM
// stub answers mem_* with one-cycle latency. A reference model built from the
// arbitration rules (who may win, when responses are due, what word they
// carry, stored in its own memory array) checks every cycle.
// ---------------------------------------------------------------------------
module tb_cpu_imem_arb;

    localparam int LIMIT = 4;
`ifdef IMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cpu_imem_arb_if bus ();

    cpu_imem_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return 32'h9E37_79B9 ^ ({24'h0, i} * 32'h0101_0101);
    endfunction

    // ---------------- RAM stub (read-before-write, one-cycle latency) -------
    logic [31:0] ram [256];
    bit          ram_w [256];
    logic [31:0] ram_q;
    assign bus.mem_rdata = ram_q;

    always @(posedge clock) begin : ram_stub
        logic [7:0]  idx;
        logic [31:0] cur;
        if (bus.mem_req) begin
            idx = bus.mem_addr[9:2];
            cur = ram_w[idx] ? ram[idx] : init_word(idx);
            ram_q <= cur;
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wstrb[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                ram[idx]   <= cur;
                ram_w[idx] <= 1'b1;
            end
        end
    end

    // ---------------- reference model state ---------------------------------
    logic [31:0] mm [256];
    bit          mm_w [256];
    bit          m_fetch_due = 1'b0;
    bit          m_data_due  = 1'b0;
    logic [31:0] m_fetch_word;
    logic [31:0] m_data_word;
    int          m_cnt = 0;
    bit          f_hold = 1'b0;
    bit          tx_granted = 1'b0;
    bit          last_gf, last_gd;
    int          fetch_grants = 0;

    function automatic logic [31:0] mread(input logic [31:0] a);
        return mm_w[a[9:2]] ? mm[a[9:2]] : init_word(a[9:2]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied (at the falling edge).
    task automatic tick();
        bit pend, force_f, gf, gd, wr;
        logic [31:0] w;
        #1;
        pend    = bus.data_req && !m_data_due;
        force_f = STARVE_ON && (m_cnt == LIMIT);
        gf      = !reset && bus.fetch_req && (!pend || force_f);
        gd      = !reset && pend && !gf;
        wr      = gd && bus.data_write;
        chk("mem_req", bus.mem_req, gf || gd);
        if (gf) chk("mem_addr_fetch", bus.mem_addr, {bus.fetch_addr[31:2], 2'b00});
        if (gd) chk("mem_addr_data", bus.mem_addr, {bus.data_addr[31:2], 2'b00});
        chk("mem_write", bus.mem_write, wr);
        chk("mem_wstrb", bus.mem_wstrb, wr ? bus.data_wstrb : 4'h0);
        if (wr) chk("mem_wdata", bus.mem_wdata, bus.data_wdata);
        chk("fetch_stall", bus.fetch_stall, !reset && bus.fetch_req && !gf);
        chk("fetch_valid", bus.fetch_valid, !reset && m_fetch_due);
        if (!reset && m_fetch_due) chk("fetch_rdata", bus.fetch_rdata, m_fetch_word);
        chk("data_ack", bus.data_ack, !reset && m_data_due);
        if (!reset && m_data_due) chk("data_rdata", bus.data_rdata, m_data_word);
        if (reset) begin
            chk("rst_mem_addr", bus.mem_addr, 32'h0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
            chk("rst_fetch_rdata", bus.fetch_rdata, 32'h0);
            chk("rst_data_rdata", bus.data_rdata, 32'h0);
        end
        last_gf = gf;
        last_gd = gd;
        if (gf) fetch_grants++;
        @(posedge clock);
        m_fetch_due = gf;
        m_data_due  = gd;
        if (gf) m_fetch_word = mread(bus.fetch_addr);
        if (gd) begin
            m_data_word = mread(bus.data_addr);
            tx_granted  = 1'b1;
            if (wr) begin
                w = m_data_word;
                for (int b = 0; b < 4; b++)
                    if (bus.data_wstrb[b]) w[8*b +: 8] = bus.data_wdata[8*b +: 8];
                mm[bus.data_addr[9:2]]   = w;
                mm_w[bus.data_addr[9:2]] = 1'b1;
            end
        end
        if (reset || gf || !bus.fetch_req) m_cnt = 0;
        else m_cnt++;
        f_hold = !reset && bus.fetch_req && !gf;
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [7:0] i;
        logic [1:0] lo;
        i  = 8'($urandom_range(64, 79));
        lo = 2'($urandom_range(0, 3));
        return {22'h0, i, lo};
    endfunction

    task automatic new_data();
        bus.data_req   = 1'b1;
        bus.data_write = 1'($urandom_range(0, 1));
        bus.data_addr  = rand_addr();
        bus.data_wdata = $urandom;
        bus.data_wstrb = 4'($urandom_range(0, 15));
        tx_granted     = 1'b0;
    endtask

    // Random stimulus that respects the hold rules of both CPU ports.
    task automatic drive_rand(input bit all_f, input bit all_d);
        if (!f_hold) begin
            bus.fetch_req  = all_f ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.fetch_addr = rand_addr();
        end
        if (!(bus.data_req && !tx_granted)) begin
            if (all_d || $urandom_range(0, 2) == 0) new_data();
            else bus.data_req = 1'b0;
        end
    endtask

    task automatic set_data(input bit req, input bit wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st);
        bus.data_req = req; bus.data_write = wr; bus.data_addr = a;
        bus.data_wdata = wd; bus.data_wstrb = st;
        tx_granted = 1'b0;
    endtask

    initial begin
        int g0;
        bus.fetch_req = 1'b1;
        bus.fetch_addr = 32'h0000_0100;
        set_data(1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF);

        // Reset held with both ports requesting: everything must stay quiet.
        @(negedge clock);
        tick();
        tick();

        // Fetch-only burst 0x100/0x104/0x108; first grant right after release.
        reset = 1'b0;
        bus.data_req = 1'b0;
        bus.fetch_addr = 32'h0000_0100; tick();
        bus.fetch_addr = 32'h0000_0104; tick();
        bus.fetch_addr = 32'h0000_0108; tick();
        bus.fetch_req = 1'b0;
        #1 chk("burst_last_valid", bus.fetch_valid, 1'b1);
        tick();

        // Write 0xDEADBEEF to 0x200 against a fetch of 0x100.
        bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0100;
        set_data(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'hF);
        #1 chk("wr_fetch_stall", bus.fetch_stall, 1'b1);
        tick();
        bus.data_req = 1'b0;
        #1 chk("wr_ack", bus.data_ack, 1'b1);
        chk("fetch_in_ack_cycle", bus.mem_addr, 32'h0000_0100);
        tick();
        bus.fetch_req = 1'b0;
        tick();

        // Read back 0x200; data_req lingers into the ack cycle.
        set_data(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        tick();
        #1 chk("rd_rdata", bus.data_rdata, 32'hDEAD_BEEF);
        chk("rd_no_regrant", bus.mem_req, 1'b0);
        tick();
        bus.data_req = 1'b0;
        tick();

        // Reset the cycle after a data grant: the ack must be dropped.
        set_data(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        tick();
        reset = 1'b1;
        bus.data_req = 1'b0;
        #1 chk("rst_drops_ack", bus.data_ack, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        set_data(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        tick();
        bus.data_req = 1'b0;
        #1 chk("post_rst_rdata", bus.data_rdata, 32'hDEAD_BEEF);
        tick();

        // Continuous data traffic with a waiting fetch: fetch must still progress.
        f_hold = 1'b0;
        tx_granted = 1'b1;
        g0 = fetch_grants;
        for (int i = 0; i < 12; i++) begin
            drive_rand(1'b1, 1'b1);
            tick();
        end
        checks++;
        assert (fetch_grants > g0) else begin
            errors++;
            $error("FAIL fetch_progress observed=%0d expected=>%0d", fetch_grants, g0);
        end

        // Randomized phase with occasional resets.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive_rand(1'b0, 1'b0);
            tick();
        end
        reset = 1'b0;
        bus.fetch_req = 1'b0;
        bus.data_req = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
